// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types, defaults and helpers for the FIFO write-port arbiter.
// The optional burst mode is enabled with the FIFO_ARB_BURST_EN macro.
package fifo_write_arbiter_pkg;

  localparam int FIFO_WIDTH    = 32;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int ARB_ID_W      = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STALL
  } arb_state_e;

  // Successor of a requester index, wrapping n-1 -> 0.
  function automatic int wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester handshake, FIFO write port and grant status shared by the arbiter and its producers.
// NUM_REQ must match the NUM_REQ of the arbiter instance this bundle is connected to.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = fifo_write_arbiter_pkg::DEF_NUM_REQ,
  parameter int DATA_W  = fifo_write_arbiter_pkg::FIFO_WIDTH
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      full;
  logic                      w_en;
  logic [DATA_W-1:0]         data_in;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_id;

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, w_en, data_in, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, full,
    input  req_ready, w_en, data_in, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester at or after rr_ptr, wrapping.
module fifo_write_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    pick_id
);

  logic [ID_W-1:0] idx;

  // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    idx     = '0;
    // Scan from the far end so the candidate nearest rr_ptr is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready requesters (wclk domain).
// Define FIFO_ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST words.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
`ifdef FIFO_ARB_BURST_EN
  , parameter int MAX_BURST = DEF_MAX_BURST
`endif
) (
  input logic                 wclk,
  input logic                 wrst_n,
  fifo_write_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    next_ptr, scan_ptr, pick_id;
  logic [NUM_REQ-1:0] owner_mask, scan_valid;
  logic [FIFO_WIDTH-1:0] data_sel;
  logic               pick_found, owner_valid, xfer, release_grant;

  assign owner_mask  = NUM_REQ'(1) << grant_id_q;
  assign owner_valid = |(bus.req_valid & owner_mask);
  assign xfer        = (state_q == GRANT) && owner_valid && !bus.full;
  assign next_ptr    = ID_W'(wrap_inc(int'(grant_id_q), NUM_REQ));

  // On release the outgoing owner is masked: its visible word was just consumed (or withdrawn).
  assign scan_ptr   = (state_q == IDLE) ? rr_ptr_q : next_ptr;
  assign scan_valid = (state_q == IDLE) ? bus.req_valid : (bus.req_valid & ~owner_mask);

  fifo_write_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_valid (scan_valid),
    .rr_ptr    (scan_ptr),
    .found     (pick_found),
    .pick_id   (pick_id)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               burst_last;
  assign burst_last = (burst_cnt_q == BURST_W'(MAX_BURST - 1));
`endif

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    release_grant = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    burst_cnt_d   = burst_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          grant_id_d = pick_id;
        end
      end
      GRANT: begin
        // Full wins over everything else: the owner is never switched while the FIFO is full.
        if (bus.full) begin
          state_d = STALL;
        end else if (!owner_valid) begin
          release_grant = 1'b1;
        end else begin
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_d   = burst_cnt_q + BURST_W'(1);
          release_grant = burst_last;
`else
          release_grant = 1'b1;
`endif
        end
      end
      STALL: begin
        if (!bus.full) state_d = GRANT;
      end
      default: state_d = IDLE;
    endcase

    if (release_grant) begin
      rr_ptr_d = next_ptr;
      state_d  = pick_found ? GRANT : IDLE;
      if (pick_found) grant_id_d = pick_id;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_d = '0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_mask[i]) data_sel = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Zero-latency datapath: the owner's word goes straight to the FIFO in its handshake cycle.
  assign bus.req_ready   = (state_q == GRANT && !bus.full) ? owner_mask : '0;
  assign bus.w_en        = xfer;
  assign bus.data_in     = xfer ? data_sel : '0;
  assign bus.grant_valid = (state_q != IDLE);
  assign bus.grant_id    = grant_id_q;

endmodule
